pipeline_id_decode: RTL and testbench

- Decode stage sitting directly downstream of the fetch stage in the 5-stage RV32I pipeline.
- Consumes the instruction and pc+4 registered by IF and decodes RV32I fields and immediates.
- Runs the static BTFN branch predictor and drives the same-cycle redirect back to IF.
- Squashes wrong-path slots and registers the decoded bundle into the ID/EX pipeline register.

---
 rtl/rv32i_pkg.sv | 56 +++++
 rtl/pipeline_id_decode_if.sv | 22 ++
 rtl/rv32i_imm_gen.sv | 36 +++
 rtl/pipeline_id_decode.sv | 132 +++++++++++++
 tb/tb_pipeline_id_decode.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rv32i_pkg.sv
// RV32I decode types shared by the ID and EX stages.
// Opcodes, opclass codes, immediate formats and the ID/EX bundle.
package rv32i_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_MISC   = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [3:0] {
    OPC_BUBBLE   = 4'd0,
    OPC_LUI      = 4'd1,
    OPC_AUIPC    = 4'd2,
    OPC_JAL      = 4'd3,
    OPC_JALR     = 4'd4,
    OPC_BRANCH   = 4'd5,
    OPC_LOAD     = 4'd6,
    OPC_STORE    = 4'd7,
    OPC_OPIMM    = 4'd8,
    OPC_OP       = 4'd9,
    OPC_MISC_MEM = 4'd10,
    OPC_SYSTEM   = 4'd11,
    OPC_ILLEGAL  = 4'd12
  } opclass_e;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_fmt_e;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic        funct7b;
    opclass_e    opc;
    logic        pred_taken;
    logic        illegal;
  } id_ex_t;

endpackage

// File: rtl/pipeline_id_decode_if.sv
// IF <-> ID link: fetched slot forward, redirect back.
// master is the fetch side, slave is the decode side.
interface pipeline_id_decode_if;
  logic [31:0] instructionF_i;
  logic [31:0] pcPlus4F_i;
  logic [31:0] redirectionD_o;
  logic        takenD_o;

  modport master (
    output instructionF_i,
    output pcPlus4F_i,
    input  redirectionD_o,
    input  takenD_o
  );

  modport slave (
    input  instructionF_i,
    input  pcPlus4F_i,
    output redirectionD_o,
    output takenD_o
  );
endinterface

// File: rtl/rv32i_imm_gen.sv
// Combinational RV32I immediate generator.
// Sign-extends the I/S/B/U/J immediate selected by fmt.
module rv32i_imm_gen
  import rv32i_pkg::*;
(
  input  logic [31:0] instr,
  input  imm_fmt_e    fmt,
  output logic [31:0] imm
);

  logic unused_op;
  assign unused_op = ^instr[6:0];

  always_comb begin
    imm = '0;
    unique case (fmt)
      IMM_I: imm = {{20{instr[31]}},
                    instr[31:20]};
      IMM_S: imm = {{20{instr[31]}},
                    instr[31:25],
                    instr[11:7]};
      IMM_B: imm = {{19{instr[31]}},
                    instr[31], instr[7],
                    instr[30:25],
                    instr[11:8], 1'b0};
      IMM_U: imm = {instr[31:12], 12'h0};
      IMM_J: imm = {{11{instr[31]}},
                    instr[31],
                    instr[19:12],
                    instr[20],
                    instr[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/pipeline_id_decode.sv
// RV32I decode stage: field/immediate decode, BTFN prediction,
// wrong-path squash and the ID/EX pipeline register.
module pipeline_id_decode
  import rv32i_pkg::*;
#(
  parameter int KILL_SLOTS = 2,
  parameter int XLEN       = 32
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            enable,
  pipeline_id_decode_if.slave ifd,
  input  logic            flushE_i,
  output logic            validE_o,
  output logic [XLEN-1:0] pcE_o,
  output logic [XLEN-1:0] immE_o,
  output logic [4:0]      rs1E_o,
  output logic [4:0]      rs2E_o,
  output logic [4:0]      rdE_o,
  output logic [2:0]      funct3E_o,
  output logic            funct7bE_o,
  output logic [3:0]      opclassE_o,
  output logic            predTakenE_o,
  output logic            illegalE_o
);

  localparam int KW = $clog2(KILL_SLOTS + 1);
  localparam logic [KW-1:0] KLOAD = KW'(KILL_SLOTS);

  logic [31:0]     instr;
  logic [6:0]      op;
  logic [XLEN-1:0] pc_d;
  logic [31:0]     imm;
  logic [KW-1:0]   kill_q;
  logic            bubble;
  logic            active;
  logic            taken;
  opclass_e        opc;
  imm_fmt_e        fmt;
  id_ex_t          d;
  id_ex_t          ex_q;

  assign instr  = ifd.instructionF_i;
  assign op     = instr[6:0];
  assign pc_d   = ifd.pcPlus4F_i - 32'd4;
  assign bubble = (instr == 32'h0)
                | (kill_q != '0);

  always_comb begin
    opc = OPC_ILLEGAL;
    fmt = IMM_NONE;
    unique case (1'b1)
      (op == OP_LUI):    begin opc = OPC_LUI;      fmt = IMM_U; end
      (op == OP_AUIPC):  begin opc = OPC_AUIPC;    fmt = IMM_U; end
      (op == OP_JAL):    begin opc = OPC_JAL;      fmt = IMM_J; end
      (op == OP_JALR):   begin opc = OPC_JALR;     fmt = IMM_I; end
      (op == OP_BRANCH): begin opc = OPC_BRANCH;   fmt = IMM_B; end
      (op == OP_LOAD):   begin opc = OPC_LOAD;     fmt = IMM_I; end
      (op == OP_STORE):  begin opc = OPC_STORE;    fmt = IMM_S; end
      (op == OP_OPIMM):  begin opc = OPC_OPIMM;    fmt = IMM_I; end
      (op == OP_OP):     begin opc = OPC_OP;       fmt = IMM_NONE; end
      (op == OP_MISC):   begin opc = OPC_MISC_MEM; fmt = IMM_I; end
      (op == OP_SYSTEM): begin opc = OPC_SYSTEM;   fmt = IMM_I; end
      default:           begin opc = OPC_ILLEGAL;  fmt = IMM_NONE; end
    endcase
  end

  rv32i_imm_gen u_imm (
    .instr (instr),
    .fmt   (fmt),
    .imm   (imm)
  );

  // BTFN: jumps always taken, branches taken only when backward.
  assign active = ~bubble & enable & ~flushE_i;
  assign taken  = active
                & ((opc == OPC_JAL)
                 | ((opc == OPC_BRANCH) & imm[31]));

  assign ifd.takenD_o       = taken;
  assign ifd.redirectionD_o = taken ? pc_d + imm
                                    : ifd.pcPlus4F_i;

  always_comb begin
    d = '0;
    if (!bubble) begin
      d.valid      = 1'b1;
      d.pc         = pc_d;
      d.imm        = imm;
      d.rs1        = instr[19:15];
      d.rs2        = instr[24:20];
      d.rd         = instr[11:7];
      d.funct3     = instr[14:12];
      d.funct7b    = instr[30];
      d.opc        = opc;
      d.pred_taken = taken;
      d.illegal    = (opc == OPC_ILLEGAL);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      ex_q   <= '0;
      kill_q <= '0;
    end else begin
      if (flushE_i)
        ex_q <= '0;
      else if (enable)
        ex_q <= d;

      if (flushE_i)
        kill_q <= KLOAD;
      else if (enable && taken)
        kill_q <= KLOAD;
      else if (enable && kill_q != '0)
        kill_q <= kill_q - 1'b1;
    end
  end

  assign validE_o     = ex_q.valid;
  assign pcE_o        = ex_q.pc;
  assign immE_o       = ex_q.imm;
  assign rs1E_o       = ex_q.rs1;
  assign rs2E_o       = ex_q.rs2;
  assign rdE_o        = ex_q.rd;
  assign funct3E_o    = ex_q.funct3;
  assign funct7bE_o   = ex_q.funct7b;
  assign opclassE_o   = ex_q.opc;
  assign predTakenE_o = ex_q.pred_taken;
  assign illegalE_o   = ex_q.illegal;

endmodule

// File: tb/tb_pipeline_id_decode.sv
// Scoreboard bench for pipeline_id_decode: directed slots
// plus randomized traffic against a behavioural model.
module tb_pipeline_id_decode;

  localparam int K = 2;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic        f7b;
    logic [3:0]  opc;
    logic        pt;
    logic        ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        resetn;
  logic        enable;
  logic        flushE_i;
  logic        validE_o;
  logic [31:0] pcE_o;
  logic [31:0] immE_o;
  logic [4:0]  rs1E_o;
  logic [4:0]  rs2E_o;
  logic [4:0]  rdE_o;
  logic [2:0]  funct3E_o;
  logic        funct7bE_o;
  logic [3:0]  opclassE_o;
  logic        predTakenE_o;
  logic        illegalE_o;

  pipeline_id_decode_if ifd_bus ();

  pipeline_id_decode #(.KILL_SLOTS(K), .XLEN(32)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .enable       (enable),
    .ifd          (ifd_bus),
    .flushE_i     (flushE_i),
    .validE_o     (validE_o),
    .pcE_o        (pcE_o),
    .immE_o       (immE_o),
    .rs1E_o       (rs1E_o),
    .rs2E_o       (rs2E_o),
    .rdE_o        (rdE_o),
    .funct3E_o    (funct3E_o),
    .funct7bE_o   (funct7bE_o),
    .opclassE_o   (opclassE_o),
    .predTakenE_o (predTakenE_o),
    .illegalE_o   (illegalE_o)
  );

  always #5 clk = ~clk;

  int   vectors = 0;
  int   miscompares = 0;
  int   km = 0;
  exp_t cur = '0;
  exp_t q[$];

  function automatic int cls(logic [31:0] i);
    int c;
    case (i[6:0])
      7'h37:   c = 1;
      7'h17:   c = 2;
      7'h6F:   c = 3;
      7'h67:   c = 4;
      7'h63:   c = 5;
      7'h03:   c = 6;
      7'h23:   c = 7;
      7'h13:   c = 8;
      7'h33:   c = 9;
      7'h0F:   c = 10;
      7'h73:   c = 11;
      default: c = 12;
    endcase
    return c;
  endfunction

  function automatic logic [31:0] immv(logic [31:0] i, int c);
    longint v;
    longint s;
    s = i[31] ? 1 : 0;
    case (c)
      4, 6, 8, 10, 11:
        v = (i >> 20) - s * 4096;
      7:
        v = ((i >> 25) << 5) + ((i >> 7) & 31) - s * 4096;
      5:
        v = s * 4096 + ((i >> 7) & 1) * 2048
          + ((i >> 25) & 63) * 32 + ((i >> 8) & 15) * 2
          - s * 8192;
      1, 2:
        v = i & 32'hFFFFF000;
      3:
        v = s * (1 << 20) + ((i >> 12) & 255) * 4096
          + ((i >> 20) & 1) * 2048 + ((i >> 21) & 1023) * 2
          - s * (1 << 21);
      default:
        v = 0;
    endcase
    return v[31:0];
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  task automatic step(bit r, bit en, bit fl,
                      logic [31:0] ins, logic [31:0] p4);
    int          c;
    logic [31:0] im;
    logic [31:0] rdir;
    bit          bub;
    bit          tk;
    @(negedge clk);
    resetn   = r;
    enable   = en;
    flushE_i = fl;
    ifd_bus.instructionF_i = ins;
    ifd_bus.pcPlus4F_i     = p4;
    c    = cls(ins);
    im   = immv(ins, c);
    bub  = (ins == 0) || (km != 0);
    tk   = !bub && en && !fl
         && (c == 3 || (c == 5 && im[31]));
    rdir = tk ? p4 - 4 + im : p4;
    #1;
    vectors++;
    if ({ifd_bus.takenD_o, ifd_bus.redirectionD_o} !== {tk, rdir}) begin
      miscompares++;
      $display("FAIL redirect got %b/%h want %b/%h",
               ifd_bus.takenD_o, ifd_bus.redirectionD_o, tk, rdir);
    end
    if (!r) begin
      cur = '0;
      km  = 0;
    end else begin
      if (fl) cur = '0;
      else if (en) begin
        cur = '0;
        if (!bub) begin
          cur.valid = 1'b1;
          cur.pc    = p4 - 4;
          cur.imm   = im;
          cur.rs1   = ins[19:15];
          cur.rs2   = ins[24:20];
          cur.rd    = ins[11:7];
          cur.f3    = ins[14:12];
          cur.f7b   = ins[30];
          cur.opc   = c[3:0];
          cur.pt    = tk;
          cur.ill   = (c == 12);
        end
      end
      if (fl) km = K;
      else if (en && tk) km = K;
      else if (en && km != 0) km = km - 1;
    end
    q.push_back(cur);
  endtask

  task automatic after_edge();
    @(posedge clk);
    #2;
  endtask

  initial begin : monitor
    exp_t e;
    exp_t a;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        a = {validE_o, pcE_o, immE_o, rs1E_o, rs2E_o, rdE_o,
             funct3E_o, funct7bE_o, opclassE_o, predTakenE_o,
             illegalE_o};
        vectors++;
        if (a !== e) begin
          miscompares++;
          $display("FAIL ex_reg got %h want %h", a, e);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "timeout");
  end

  localparam logic [31:0] ADDI = 32'h00100093;
  localparam logic [6:0] OPS [14] = '{
    7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23,
    7'h13, 7'h33, 7'h0F, 7'h73, 7'h7F, 7'h0B, 7'h00};

  initial begin : stim
    logic [31:0] ins;
    resetn = 1'b0;
    enable = 1'b0;
    flushE_i = 1'b0;
    ifd_bus.instructionF_i = '0;
    ifd_bus.pcPlus4F_i = 32'h4;
    step(0, 0, 0, 0, 32'h4);
    step(0, 1, 0, 0, 32'h4);
    after_edge();
    chk("rst_valid", {31'h0, validE_o}, 0);
    chk("rst_opc", {28'h0, opclassE_o}, 0);
    chk("rst_pc", pcE_o, 0);

    step(1, 1, 0, 0, 32'h4);
    chk("zero_taken", {31'h0, ifd_bus.takenD_o}, 0);
    after_edge();
    chk("zero_valid", {31'h0, validE_o}, 0);
    chk("zero_imm", immE_o, 0);

    step(1, 1, 0, 32'hFE000CE3, 32'h104);
    chk("bwd_taken", {31'h0, ifd_bus.takenD_o}, 1);
    chk("bwd_target", ifd_bus.redirectionD_o, 32'hF8);
    after_edge();
    chk("bwd_valid", {31'h0, validE_o}, 1);
    chk("bwd_pt", {31'h0, predTakenE_o}, 1);
    chk("bwd_pc", pcE_o, 32'h100);
    chk("bwd_imm", immE_o, 32'hFFFFFFF8);
    for (int i = 0; i < 2; i++) begin
      step(1, 1, 0, ADDI, 32'h108 + 4 * i);
      after_edge();
      chk("kill_valid", {31'h0, validE_o}, 0);
    end

    step(1, 1, 0, 32'h00000863, 32'h204);
    chk("fwd_taken", {31'h0, ifd_bus.takenD_o}, 0);
    chk("fwd_redir", ifd_bus.redirectionD_o, 32'h204);
    after_edge();
    chk("fwd_pt", {31'h0, predTakenE_o}, 0);
    chk("fwd_imm", immE_o, 32'h10);

    step(1, 1, 0, 32'h0200006F, 32'h44);
    chk("jal_taken", {31'h0, ifd_bus.takenD_o}, 1);
    chk("jal_target", ifd_bus.redirectionD_o, 32'h60);
    after_edge();
    chk("jal_opc", {28'h0, opclassE_o}, 3);
    step(1, 1, 0, ADDI, 32'h64);
    step(1, 1, 0, ADDI, 32'h68);

    step(1, 1, 1, 32'hFE000CE3, 32'h104);
    chk("flush_taken", {31'h0, ifd_bus.takenD_o}, 0);
    after_edge();
    chk("flush_valid", {31'h0, validE_o}, 0);
    step(1, 1, 0, ADDI, 32'h300);
    step(1, 1, 0, ADDI, 32'h304);
    step(1, 1, 0, 32'hFFF00293, 32'h308);
    after_edge();
    chk("post_valid", {31'h0, validE_o}, 1);
    chk("post_rd", {27'h0, rdE_o}, 5);
    chk("post_imm", immE_o, 32'hFFFFFFFF);
    chk("post_opc", {28'h0, opclassE_o}, 8);

    step(1, 1, 0, 32'hFE000CE3, 32'h104);
    step(1, 1, 0, ADDI, 32'h108);
    for (int i = 0; i < 3; i++)
      step(1, 0, 0, ADDI, 32'h10C);
    step(1, 1, 0, ADDI, 32'h10C);
    after_edge();
    chk("resume_kill", {31'h0, validE_o}, 0);
    step(1, 1, 0, 32'hFFF00293, 32'h110);
    after_edge();
    chk("resume_valid", {31'h0, validE_o}, 1);

    for (int n = 0; n < 2000; n++) begin
      ins = $urandom;
      ins[6:0] = OPS[$urandom_range(13)];
      if ($urandom_range(15) == 0) ins = '0;
      step($urandom_range(199) != 0,
           $urandom_range(4) != 0,
           $urandom_range(9) == 0,
           ins, $urandom);
    end

    after_edge();
    chk("sb_drain", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
